// File: rtl/uart_rx_param_if.sv
// Host-side bundle of the UART receiver: received word, valid/ready handshake,
// busy flag and the one-cycle error pulses.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 busy;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun_err;

  modport master (
    output rx_data, rx_valid, busy, frame_err, parity_err, overrun_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, busy, frame_err, parity_err, overrun_err,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_param.sv
// Oversampled mid-bit UART receiver with false-start rejection, framing/overrun
// detection and a valid/ready output register. Parity via UART_RX_PARITY_EN.
//
// state  | meaning
// IDLE   | waiting for a falling edge on rx_s
// START  | confirming the start bit at half a bit period
// DATA   | sampling DATA_BITS data bits at bit centres
// PARITY | sampling the parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling the stop bit, then delivering or reporting
module uart_rx_param #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_ODD  = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx,
  uart_rx_param_if.master bus
);
  localparam int DIV = CLK_FREQ_HZ / (BAUD_RATE * OVERSAMPLE);
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS + 1);

  localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);
  localparam logic [SW-1:0] SAMP_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SAMP_FULL = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  if (DIV < 1 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 ||
      DATA_BITS < 5 || DATA_BITS > 9 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_rx_param: illegal parameter set");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_meta, rx_s, rx_prev;
  logic [PW-1:0]        pre_cnt;
  logic [SW-1:0]        samp_cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 tick;
  logic                 clr_cnt, samp_hit, shift_en, stop_en;
  logic [DATA_BITS-1:0] word;
  logic                 par_bad;
  logic                 good, load;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, frame_q, parity_q, overrun_q;

  // rx is asynchronous; rx_prev feeds the start edge detector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    clr_cnt  = 1'b0;
    samp_hit = 1'b0;
    shift_en = 1'b0;
    stop_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_prev && !rx_s) begin
          clr_cnt = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (tick && samp_cnt == SAMP_HALF) begin
          samp_hit = 1'b1;
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            clr_cnt = 1'b1;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (tick && samp_cnt == SAMP_FULL) begin
          samp_hit = 1'b1;
          shift_en = 1'b1;
          if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick && samp_cnt == SAMP_FULL) begin
          samp_hit = 1'b1;
          state_d  = STOP;
        end
      end
`endif
      STOP: begin
        if (tick && samp_cnt == SAMP_FULL) begin
          samp_hit = 1'b1;
          stop_en  = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // sample counter is parked at zero in IDLE so it never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt  <= '0;
      samp_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      if (clr_cnt || tick) pre_cnt <= '0;
      else                 pre_cnt <= pre_cnt + 1'b1;

      if (clr_cnt || samp_hit || state_q == IDLE) samp_cnt <= '0;
      else if (tick)                              samp_cnt <= samp_cnt + 1'b1;

      if (clr_cnt)       bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        word <= '0;
    else if (shift_en) word <= {rx_s, word[DATA_BITS-1:1]};
  end

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  logic par_en;
  assign par_en = (state_q == PARITY) && samp_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      par_bad <= 1'b0;
    else if (clr_cnt) par_bad <= 1'b0;
    else if (par_en)  par_bad <= rx_s ^ (^word) ^ PAR_ODD;
  end
`else
  assign par_bad = 1'b0;
`endif

  // a good word loads if the output register is empty or being drained now
  assign good = rx_s && !par_bad;
  assign load = stop_en && good && (!valid_q || bus.rx_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      frame_q   <= 1'b0;
      parity_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      frame_q   <= stop_en && !rx_s;
      parity_q  <= stop_en && par_bad;
      overrun_q <= stop_en && good && valid_q && !bus.rx_ready;
      if (load) begin
        data_q  <= word;
        valid_q <= 1'b1;
      end else if (valid_q && bus.rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.rx_data     = data_q;
  assign bus.rx_valid    = valid_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.frame_err   = frame_q;
  assign bus.parity_err  = parity_q;
  assign bus.overrun_err = overrun_q;
endmodule
